// File: rtl/inst_sequencer_if.sv
// ---------------------------------------------------------------------------
// inst_sequencer_if
//   Groups the instruction words, bus handshake and status outputs of the
//   instruction-cycle sequencer.
//
//   Handshake: i_mem_rdy is sampled on every rising edge while the sequencer
//   sits in a memory state (IF1, IF2, IF3, PUSH2, POP2, RD, WR). A cycle with
//   i_mem_rdy=1 completes that access and the state advances. A cycle with
//   i_mem_rdy=0 holds the state and asserts o_wait. i_mem_rdy carries no
//   meaning in any other state.
//
//   Signals
//     i_ir1      : first instruction word (valid in IF1)
//     i_ir2      : second instruction word (valid in IF2)
//     i_mem_rdy  : bus ready, completes the current memory-state access
//     i_resume   : level, leaves HALT
//     o_state    : one-hot current state
//     o_state_id : binary current state id
//     o_wait     : memory state stalled on i_mem_rdy=0
//     o_halt     : in HALT
//     o_err      : in ERR (sticky until reset)
//
//   Modports
//     master : the side that drives the IR words and the bus ready
//     slave  : the sequencer
// ---------------------------------------------------------------------------
interface inst_sequencer_if #(
  parameter int DATA_W  = 16,
  parameter int STATE_W = 16
);
  logic [DATA_W-1:0]  i_ir1;
  logic [DATA_W-1:0]  i_ir2;
  logic               i_mem_rdy;
  logic               i_resume;
  logic [STATE_W-1:0] o_state;
  logic [3:0]         o_state_id;
  logic               o_wait;
  logic               o_halt;
  logic               o_err;

  modport master (
    output i_ir1, i_ir2, i_mem_rdy, i_resume,
    input  o_state, o_state_id, o_wait, o_halt, o_err
  );

  modport slave (
    input  i_ir1, i_ir2, i_mem_rdy, i_resume,
    output o_state, o_state_id, o_wait, o_halt, o_err
  );
endinterface

// File: rtl/inst_sequencer.sv
// ---------------------------------------------------------------------------
// inst_sequencer
//   Instruction-cycle controller. Walks fetch / optional immediate fetch /
//   push / pop / execute / memory read-write micro-states, stalls on bus
//   wait-states, traps illegal opcodes and stuck buses into ERR, and parks
//   in HALT until i_resume.
//
//   Ports
//     i_clk : clock, rising edge
//     i_rst : synchronous active-high reset (state -> IF1, watchdog -> 0)
//     bus   : inst_sequencer_if.slave (IR words, ready/resume, status)
//
//   The datapath decodes o_state (one-hot, bit index = state id) to drive
//   its register enables; o_state_id is the same state in binary.
// ---------------------------------------------------------------------------
module inst_sequencer #(
  parameter int         DATA_W   = 16,
  parameter int         STATE_W  = 16,
  parameter logic [3:0] IMM_CODE = 4'h3,
  parameter int         TIMEOUT  = 256
) (
  input logic              i_clk,
  input logic              i_rst,
  inst_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IF1   = 4'd0,
    S_IF2   = 4'd1,
    S_IF3   = 4'd2,
    S_PUSH1 = 4'd3,
    S_PUSH2 = 4'd4,
    S_POP1  = 4'd5,
    S_POP2  = 4'd6,
    S_EXE   = 4'd7,
    S_RD    = 4'd8,
    S_WR    = 4'd9,
    S_HALT  = 4'd10,
    S_ERR   = 4'd11
  } state_t;

  // TIMEOUT=0 disables the watchdog; keep a 1-bit counter so the logic
  // still elaborates cleanly.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wd_cnt;
  logic [3:0]       r_op;
  logic [3:0]       w_op;
  logic             w_imm;
  logic             w_is_mem;
  logic             w_rdy;
  logic             w_timeout;
  logic             w_unused_bits;

  assign w_op  = bus.i_ir1[DATA_W-1 -: 4];
  assign w_rdy = bus.i_mem_rdy;
  assign w_imm = (bus.i_ir2[DATA_W-1 -: 4] == IMM_CODE) ||
                 (bus.i_ir2[DATA_W-5 -: 4] == IMM_CODE);
  assign w_unused_bits = ^{bus.i_ir1[DATA_W-5:0], bus.i_ir2[DATA_W-9:0]};

  always_comb begin
    w_is_mem = 1'b0;
    case (r_state)
      S_IF1, S_IF2, S_IF3, S_PUSH2, S_POP2, S_RD, S_WR: w_is_mem = 1'b1;
      default:                                          w_is_mem = 1'b0;
    endcase
  end

  // Stuck bus: the last allowed not-ready cycle traps; ready on that same
  // cycle still lets the access complete normally.
  assign w_timeout = (TIMEOUT != 0) && w_is_mem && !w_rdy && (r_wd_cnt == CNT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IF1: begin
        if (w_rdy) begin
          case (w_op)
            4'b1101:          w_next = S_PUSH1;
            4'b1100:          w_next = S_POP1;
            4'b1111:          w_next = S_HALT;
            4'b1010, 4'b1110: w_next = S_ERR;
            default:          w_next = S_IF2;
          endcase
        end
      end
      S_IF2:   if (w_rdy) w_next = w_imm ? S_IF3 : S_EXE;
      S_IF3:   if (w_rdy) w_next = S_EXE;
      // r_op is the opcode captured when IF1 completed, so i_ir1 only has
      // to be valid during IF1.
      S_EXE: begin
        case (r_op)
          4'b1000: w_next = S_RD;
          4'b1001: w_next = S_WR;
          4'b1011: w_next = S_PUSH1;
          default: w_next = S_IF1;
        endcase
      end
      S_PUSH1: w_next = S_PUSH2;
      S_PUSH2: if (w_rdy) w_next = S_IF1;
      S_POP1:  w_next = S_POP2;
      S_POP2:  if (w_rdy) w_next = S_IF1;
      S_RD:    if (w_rdy) w_next = S_IF1;
      S_WR:    if (w_rdy) w_next = S_IF1;
      S_HALT:  if (bus.i_resume) w_next = S_IF1;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
    if (w_timeout) w_next = S_ERR;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IF1;
      r_wd_cnt <= '0;
      r_op     <= 4'h0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wd_cnt <= '0;
      end else if (w_is_mem && !w_rdy) begin
        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
      end
      if ((r_state == S_IF1) && w_rdy) begin
        r_op <= w_op;
      end
    end
  end

  assign bus.o_state    = STATE_W'(1) << r_state;
  assign bus.o_state_id = r_state;
  assign bus.o_wait     = w_is_mem & ~w_rdy;
  assign bus.o_halt     = (r_state == S_HALT);
  assign bus.o_err      = (r_state == S_ERR);

endmodule

// File: tb/tb_inst_sequencer.sv
module tb_inst_sequencer;
  localparam int DW = 16;
  localparam int SW = 16;
  localparam int TO = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ir1 = '0;
  logic [DW-1:0] ir2 = '0;
  logic          rdy = 1'b1;
  logic          resume = 1'b0;

  inst_sequencer_if #(.DATA_W(DW), .STATE_W(SW)) bus ();
  assign bus.i_ir1     = ir1;
  assign bus.i_ir2     = ir2;
  assign bus.i_mem_rdy = rdy;
  assign bus.i_resume  = resume;

  inst_sequencer #(.DATA_W(DW), .STATE_W(SW), .IMM_CODE(4'h3), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An instruction is a route: the list of states it visits after IF1.
  // Memory states move along the route only on ready cycles.
  int m_cur = 0;
  int m_cnt = 0;
  bit m_on  = 1'b0;
  int m_route[$];

  function automatic bit is_mem(input int s);
    return (s == 0) || (s == 1) || (s == 2) || (s == 4) || (s == 6) || (s == 8) || (s == 9);
  endfunction

  task automatic build_route(input logic [3:0] op);
    m_route.delete();
    case (op)
      4'hD: begin m_route.push_back(3); m_route.push_back(4); m_route.push_back(0); end
      4'hC: begin m_route.push_back(5); m_route.push_back(6); m_route.push_back(0); end
      4'hF: m_route.push_back(10);
      4'hA, 4'hE: m_route.push_back(11);
      4'h8: begin m_route.push_back(1); m_route.push_back(7); m_route.push_back(8); m_route.push_back(0); end
      4'h9: begin m_route.push_back(1); m_route.push_back(7); m_route.push_back(9); m_route.push_back(0); end
      4'hB: begin
        m_route.push_back(1); m_route.push_back(7); m_route.push_back(3);
        m_route.push_back(4); m_route.push_back(0);
      end
      default: begin m_route.push_back(1); m_route.push_back(7); m_route.push_back(0); end
    endcase
  endtask

  always @(posedge clk) begin
    int nxt;
    if (rst) begin
      m_cur = 0;
      m_cnt = 0;
      m_on  = 1'b1;
      m_route.delete();
    end else if (m_on) begin
      nxt = m_cur;
      if (m_cur == 11) begin
        nxt = 11;
      end else if (m_cur == 10) begin
        nxt = resume ? 0 : 10;
      end else if (is_mem(m_cur) && !rdy) begin
        if (m_cnt == TO - 1) nxt = 11;
      end else begin
        if (m_cur == 0) build_route(ir1[15:12]);
        else if (m_cur == 1 && (ir2[15:12] == 4'h3 || ir2[11:8] == 4'h3)) m_route.push_front(2);
        nxt = m_route.pop_front();
      end
      if (nxt != m_cur) m_cnt = 0;
      else if (is_mem(m_cur) && !rdy) m_cnt++;
      m_cur = nxt;
    end
  end

  // one compare process: every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (m_on) begin
      check("state_id", 32'(bus.o_state_id), 32'(m_cur));
      check("state_onehot", 32'(bus.o_state), 32'd1 << m_cur);
      check("halt", 32'(bus.o_halt), 32'(m_cur == 10));
      check("err", 32'(bus.o_err), 32'(m_cur == 11));
      check("wait", 32'(bus.o_wait), 32'(is_mem(m_cur) && !rdy));
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic step();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // seq holds the expected state ids as hex nibbles, first one most significant
  task automatic run_seq(input logic [15:0] i1, input logic [15:0] i2, input int n,
                         input logic [31:0] seq);
    logic [31:0] e;
    ir1 = i1; ir2 = i2; rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = (seq >> (4 * (n - 1 - i))) & 32'hF;
      @(negedge clk);
      check("seq_dut", 32'(bus.o_state_id), e);
      check("seq_model", 32'(m_cur), e);
      @(posedge clk); #1;
    end
  endtask

  task automatic rst_check(input string name);
    ir1 = 16'h0123; ir2 = 16'h0000; rdy = 1'b0; resume = 1'b0;
    do_reset();
    @(negedge clk);
    check({name, "_onehot"}, 32'(bus.o_state), 32'd1);
    check({name, "_id"}, 32'(bus.o_state_id), 32'd0);
    check({name, "_wait"}, 32'(bus.o_wait), 32'd1);
    @(posedge clk); #1;
    rdy = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lowrun;
    lowrun = 0;

    // reset state, with rdy low so o_wait is visible in IF1
    rst = 1'b1; rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_onehot", 32'(bus.o_state), 32'd1);
    check("rst_id", 32'(bus.o_state_id), 32'd0);
    check("rst_halt", 32'(bus.o_halt), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    check("rst_wait", 32'(bus.o_wait), 32'd1);
    @(posedge clk); #1;

    // basic instruction routes
    run_seq(16'h0123, 16'h0000, 3, 32'h017);
    run_seq(16'h8000, 16'h3000, 5, 32'h01278);
    run_seq(16'h8000, 16'h0300, 5, 32'h01278);
    run_seq(16'hB000, 16'h0000, 5, 32'h01734);
    run_seq(16'hD000, 16'h0000, 3, 32'h034);
    run_seq(16'hC000, 16'h0000, 3, 32'h056);

    // RD wait-states: 5 stalled cycles, then ready
    run_seq(16'h8000, 16'h0000, 3, 32'h017);
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rd_hold", 32'(bus.o_state_id), 32'd8);
      check("rd_wait", 32'(bus.o_wait), 32'd1);
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    @(negedge clk);
    check("rd_ready_id", 32'(bus.o_state_id), 32'd8);
    check("rd_ready_wait", 32'(bus.o_wait), 32'd0);
    @(posedge clk); #1;

    // watchdog trap: TO not-ready cycles in IF1
    ir1 = 16'h0123; ir2 = 16'h0000; rdy = 1'b0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      check("wd_hold", 32'(bus.o_state_id), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("wd_trap_id", 32'(bus.o_state_id), 32'd11);
    check("wd_trap_err", 32'(bus.o_err), 32'd1);
    @(posedge clk); #1;
    rdy = 1'b1; resume = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("err_sticky", 32'(bus.o_err), 32'd1);
      @(posedge clk); #1;
    end
    resume = 1'b0;

    // watchdog escape: ready arrives on the last allowed cycle
    ir1 = 16'h0123; rdy = 1'b0;
    do_reset();
    for (int k = 0; k < TO - 1; k++) step();
    rdy = 1'b1;
    @(negedge clk);
    check("wd_last_id", 32'(bus.o_state_id), 32'd0);
    @(posedge clk); #1;
    run_seq(16'h0123, 16'h0000, 2, 32'h17);

    // HALT held for 10 cycles, then resume pulse
    run_seq(16'hF000, 16'h0000, 1, 32'h0);
    for (int k = 0; k < 10; k++) begin
      rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_hold", 32'(bus.o_state_id), 32'd10);
      check("halt_flag", 32'(bus.o_halt), 32'd1);
      @(posedge clk); #1;
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    run_seq(16'hA000, 16'h0000, 2, 32'h0B);   // back in IF1, then illegal

    // reset overrides ERR, HALT and a stalled memory state
    rst_check("rst_mid_err");
    run_seq(16'hF000, 16'h0000, 2, 32'h0A);
    rst_check("rst_mid_halt");
    run_seq(16'h8000, 16'h0000, 3, 32'h017);
    rdy = 1'b0;
    step(); step();
    rst_check("rst_mid_wait");

    // randomized phase, checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      rst = (m_cur == 11) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
      if (lowrun > 0) begin
        rdy = 1'b0;
        lowrun--;
      end else if ($urandom_range(0, 40) == 0) begin
        rdy = 1'b0;
        lowrun = $urandom_range(3, 8);
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      resume = ($urandom_range(0, 5) == 0);
      if (m_cur == 0) begin
        ir1 = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       ir2 = {4'h3, 12'($urandom)};
          1:       ir2 = {4'($urandom), 4'h3, 8'($urandom)};
          default: ir2 = 16'($urandom);
        endcase
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Parametrised successor of the NLP-16AF instruction-cycle controller.
- Walks the per-instruction micro-state sequence: fetch, optional immediate fetch, push/pop, execute, memory read/write.
- Adds memory wait-states via a ready handshake, a wait-timeout watchdog, illegal-opcode trapping, and a HALT/resume mode.
- Sits between the IR registers and the datapath/bus control; the datapath decodes o_state to drive register enables.

Parameters:
- DATA_W, 16: IR word width; must be >= 16. The opcode is i_ir1[DATA_W-1 -: 4].
- STATE_W, 16: width of the one-hot o_state bus; must be >= 12.
- IMM_CODE, 4'h3: operand-field code that selects a 16-bit immediate (extra fetch).
- TIMEOUT, 256: maximum consecutive not-ready cycles in a memory state before trapping; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_ir1  in  DATA_W  first instruction word; must be valid while in IF1.
- i_ir2  in  DATA_W  second instruction word; must be valid while in IF2.
- i_mem_rdy  in  1  bus ready; completes the current memory-state access.
- i_resume  in  1  level; leaves HALT.
- o_state  out  STATE_W  one-hot current state; bit index = state id; unused high bits are 0.
- o_state_id  out  4  binary current state id.
- o_wait  out  1  high when in a memory state and i_mem_rdy=0.
- o_halt  out  1  high in HALT.
- o_err  out  1  high in ERR; sticky.

Behaviour:
- State ids: IF1=0, IF2=1, IF3=2, PUSH1=3, PUSH2=4, POP1=5, POP2=6, EXE=7, RD=8, WR=9, HALT=10, ERR=11.
- Memory states are IF1, IF2, IF3, PUSH2, POP2, RD and WR. They advance only on a cycle where i_mem_rdy=1; otherwise they hold.
- All other states advance unconditionally every cycle.
- Opcode classes (op = i_ir1[DATA_W-1 -: 4]):
  - ALU: op[3:2]=00
  - load: 1000
  - store: 1001
  - call: 1011
  - pop: 1100
  - push: 1101
  - halt: 1111
  - illegal: 1010 and 1110
  - opcodes 01xx are non-memory ops and execute like ALU.
- Immediate flag: im = (i_ir2[DATA_W-1 -: 4]==IMM_CODE) or (i_ir2[DATA_W-5 -: 4]==IMM_CODE). It is evaluated only on the IF2 completing cycle.
- Transitions (memory states only when ready):
  - IF1: push -> PUSH1; pop -> POP1; halt -> HALT; illegal -> ERR; else -> IF2.
  - IF2: im -> IF3; else -> EXE.
  - IF3 -> EXE.
  - EXE: load -> RD; store -> WR; call -> PUSH1; else -> IF1.
  - PUSH1 -> PUSH2 -> IF1.
  - POP1 -> POP2 -> IF1.
  - RD -> IF1. WR -> IF1.
  - HALT: i_resume=1 -> IF1; else stay.
  - ERR: stay until i_rst.
  - Unencoded state value -> ERR.
- Watchdog:
  - Counter width is clog2(TIMEOUT+1).
  - It clears on every state change and increments each cycle a memory state holds with i_mem_rdy=0.
  - When count==TIMEOUT-1 and i_mem_rdy=0, next state is ERR.
  - i_mem_rdy=1 on that same cycle wins: normal advance, no trap.
- Reset:
  - On the edge with i_rst=1: state=IF1 and counter=0.
  - Resulting outputs: o_state=1, o_state_id=0, o_halt=0, o_err=0. o_wait then follows i_mem_rdy (IF1 is a memory state).
  - Reset overrides everything, including mid-wait, HALT and ERR.
- Latency: state is registered. All outputs are combinational from the state register, except o_wait, which also uses i_mem_rdy.
- Simultaneous events: i_resume is ignored outside HALT; i_mem_rdy is ignored in non-memory states.

Test Plan:
- Reset then ALU op (ir1=16'h0123, ir2=16'h0000, rdy=1) -> o_state_id sequence 0,1,7,0; o_err=0.
- Load with immediate (ir1=16'h8000, ir2=16'h3000, rdy=1) -> 0,1,2,7,8,0. Repeat with ir2=16'h0300 -> same sequence.
- Call (ir1=16'hB000, ir2=16'h0000) -> 0,1,7,3,4,0. Push 16'hD000 -> 0,3,4,0. Pop 16'hC000 -> 0,5,6,0.
- Wait states: RD with rdy low 5 cycles -> state 8 held 5 cycles with o_wait=1, then IF1 on the cycle after rdy rises.
- Watchdog (TIMEOUT=4): rdy=0 in IF1 -> state 0 for 4 cycles then ERR, o_err=1 and sticky. Repeat with rdy=1 on the 4th wait cycle -> no trap.
- Halt 16'hF000 -> HALT, o_halt=1, held across 10 cycles; i_resume pulse -> IF1. Illegal 16'hA000 -> ERR. i_rst asserted mid-HALT, mid-ERR and mid-wait -> IF1, o_state=1 next edge.
